// File: rtl/node_pkg.sv
// Shared types and default sizing for the ANN node sequencer.
package node_pkg;

   localparam int IMAGE_SIZE = 64;
   localparam int CNT_W      = 7;
   localparam int DATA_W     = 16;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      ACCUM,
      SETTLE,
      DONE
   } seq_state_t;

   typedef logic [DATA_W-1:0] fxp_t;

endpackage

// File: rtl/seq_counter.sv
// Product-term index counter for the node sequencer.
// Counts 0..TERMS-1 while enabled, then returns to zero; tc flags the last term.
module seq_counter
   import node_pkg::*;
#(
   parameter int TERMS = IMAGE_SIZE,
   parameter int WIDTH = CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] cnt,
   output logic             tc
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMS - 1);

   assign tc = (cnt == LAST);

   // Index register: cleared by reset or clear, otherwise steps and folds back to zero after the last term
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= tc ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/node_sequencer.sv
// Control-side partner of the ANN node: runs one multiply-accumulate pass per
// image, captures the activated node output and offers it downstream.
module node_sequencer
   import node_pkg::*;
#(
   parameter int IMAGE_SIZE = node_pkg::IMAGE_SIZE,
   parameter int CNT_W      = node_pkg::CNT_W,
   parameter int DATA_W     = node_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              img_valid,
   output logic              img_ready,
   output logic              reset_acc,
   output logic              start,
   output logic [CNT_W-1:0]  cnt_val,
   input  logic [DATA_W-1:0] node_out,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              busy
);

   seq_state_t       state;
   seq_state_t       next_state;
   logic [CNT_W-1:0] cnt;
   logic             cnt_tc;
   logic             cnt_clear;
   logic             cnt_en;

   assign cnt_en    = (state == ACCUM);
   assign cnt_clear = (state != ACCUM);

   seq_counter #(
      .TERMS (IMAGE_SIZE),
      .WIDTH (CNT_W)
   ) u_counter (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .cnt    (cnt),
      .tc     (cnt_tc)
   );

   // State register; reset abandons any image in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode: one clear cycle, IMAGE_SIZE accumulate cycles, one settle cycle, then hold until drained
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (img_valid)    next_state = CLEAR;
         CLEAR:                     next_state = ACCUM;
         ACCUM:   if (cnt_tc)       next_state = SETTLE;
         SETTLE:                    next_state = DONE;
         DONE:    if (result_ready) next_state = IDLE;
         default:                   next_state = IDLE;
      endcase
   end

   // Output decode from state and count only, so no input reaches an output combinationally
   always_comb begin
      img_ready    = 1'b0;
      reset_acc    = 1'b0;
      start        = 1'b1;
      cnt_val      = '0;
      result_valid = 1'b0;
      busy         = 1'b1;
      case (state)
         IDLE: begin
            img_ready = 1'b1;
            busy      = 1'b0;
         end
         CLEAR: begin
            reset_acc = 1'b1;
         end
         ACCUM: begin
            start   = 1'b0;
            cnt_val = cnt;
         end
         SETTLE: begin
         end
         DONE: begin
            result_valid = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Result capture: the node is holding its final sum during SETTLE, the only cycle that writes result
   always_ff @(posedge clk) begin
      if (rst) begin
         result <= '0;
      end else if (state == SETTLE) begin
         result <= node_out;
      end
   end

endmodule

// File: tb/tb_node_sequencer.sv
// Testbench for node_sequencer: behavioural node models, scoreboard of expected
// image results, one task per scenario.
module tb_node_sequencer;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 7;
   localparam int BIG    = 64;
   localparam int SMALL  = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              img_valid,  img_valid2;
   logic              result_ready, result_ready2;
   logic              img_ready,  img_ready2;
   logic              reset_acc,  reset_acc2;
   logic              start,      start2;
   logic [CNT_W-1:0]  cnt_val,    cnt_val2;
   logic [DATA_W-1:0] node_out,   node_out2;
   logic [DATA_W-1:0] result,     result2;
   logic              result_valid, result_valid2;
   logic              busy,       busy2;

   int checks = 0;
   int passed = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] exp_q2[$];

   node_sequencer #(.IMAGE_SIZE(BIG), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .img_valid    (img_valid),
      .img_ready    (img_ready),
      .reset_acc    (reset_acc),
      .start        (start),
      .cnt_val      (cnt_val),
      .node_out     (node_out),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .busy         (busy)
   );

   node_sequencer #(.IMAGE_SIZE(SMALL), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut_small (
      .clk          (clk),
      .rst          (rst),
      .img_valid    (img_valid2),
      .img_ready    (img_ready2),
      .reset_acc    (reset_acc2),
      .start        (start2),
      .cnt_val      (cnt_val2),
      .node_out     (node_out2),
      .result       (result2),
      .result_valid (result_valid2),
      .result_ready (result_ready2),
      .busy         (busy2)
   );

   // Expected node result: sum of all term indices with identity activation
   function automatic logic [DATA_W-1:0] expected_sum(input int n);
      int s;
      s = 0;
      for (int i = 0; i < n; i++) s += i;
      return DATA_W'(s);
   endfunction

   // Behavioural nodes: accumulate cnt_val whenever start is low, identity activation
   logic [DATA_W-1:0] acc  = '0;
   logic [DATA_W-1:0] acc2 = '0;
   assign node_out  = acc;
   assign node_out2 = acc2;

   always @(posedge clk) begin
      if (rst || reset_acc) acc <= '0;
      else if (!start)      acc <= acc + DATA_W'(cnt_val);
      if (rst || reset_acc2) acc2 <= '0;
      else if (!start2)      acc2 <= acc2 + DATA_W'(cnt_val2);
   end

   // Scoreboard feed: every accepted image queues its expected result
   always @(posedge clk) begin
      if (!rst && img_valid  && img_ready)  exp_q.push_back(expected_sum(BIG));
      if (!rst && img_valid2 && img_ready2) exp_q2.push_back(expected_sum(SMALL));
   end

   task automatic test_reset();
      rst = 1'b1;
      img_valid = 1'b0; img_valid2 = 1'b0;
      result_ready = 1'b0; result_ready2 = 1'b0;
      @(negedge clk); @(negedge clk);
      checks++;
      if ({img_ready, reset_acc, start, result_valid, busy} !== 5'b10100)
         $display("[TB] FAIL reset_flags: got %b expected 10100", {img_ready, reset_acc, start, result_valid, busy});
      else passed++;
      checks++;
      if (cnt_val !== '0) $display("[TB] FAIL reset_cnt_val: got %0d expected 0", cnt_val);
      else passed++;
      checks++;
      if (result !== '0) $display("[TB] FAIL reset_result: got %h expected 0000", result);
      else passed++;
      rst = 1'b0;
      exp_q.delete(); exp_q2.delete();
      @(negedge clk);
      checks++;
      if ({img_ready, busy, img_ready2, busy2} !== 4'b1010)
         $display("[TB] FAIL post_reset_idle: got %b expected 1010", {img_ready, busy, img_ready2, busy2});
      else passed++;
   endtask

   task automatic test_single();
      logic [DATA_W-1:0] exp;
      result_ready = 1'b1;
      img_valid = 1'b1;
      checks++;
      if (img_ready !== 1'b1) $display("[TB] FAIL single_img_ready: got %b expected 1", img_ready);
      else passed++;
      @(negedge clk);
      img_valid = 1'b0;
      checks++;
      if ({reset_acc, start, busy, img_ready} !== 4'b1110)
         $display("[TB] FAIL single_clear: got %b expected 1110", {reset_acc, start, busy, img_ready});
      else passed++;
      for (int i = 0; i < BIG; i++) begin
         @(negedge clk);
         checks++;
         if ({start, reset_acc} !== 2'b00 || cnt_val !== CNT_W'(i))
            $display("[TB] FAIL single_accum_%0d: got start=%b reset_acc=%b cnt_val=%0d expected 0 0 %0d", i, start, reset_acc, cnt_val, i);
         else passed++;
      end
      @(negedge clk);
      checks++;
      if ({start, result_valid, busy} !== 3'b101 || cnt_val !== '0)
         $display("[TB] FAIL single_settle: got %b cnt_val=%0d expected 101 cnt_val=0", {start, result_valid, busy}, cnt_val);
      else passed++;
      @(negedge clk);
      checks++;
      if (result_valid !== 1'b1) $display("[TB] FAIL single_latency: got result_valid=%b expected 1 at T+67", result_valid);
      else passed++;
      exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      checks++;
      if (result !== exp) $display("[TB] FAIL single_result: got %h expected %h", result, exp);
      else passed++;
      @(negedge clk);
      checks++;
      if ({result_valid, img_ready, busy} !== 3'b010 || result !== 16'h07E0)
         $display("[TB] FAIL single_drain: got %b result=%h expected 010 result=07e0", {result_valid, img_ready, busy}, result);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] exp;
      int n;
      result_ready = 1'b0;
      img_valid = 1'b1;
      @(negedge clk);
      img_valid = 1'b0;
      n = 1;
      while (result_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 67) $display("[TB] FAIL bp_latency: got %0d cycles expected 67", n);
      else passed++;
      exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if ({result_valid, img_ready} !== 2'b10 || result !== exp)
            $display("[TB] FAIL bp_hold_%0d: got valid/ready=%b result=%h expected 10 result=%h", i, {result_valid, img_ready}, result, exp);
         else passed++;
         img_valid = (i >= 5 && i < 15);
         @(negedge clk);
      end
      img_valid = 1'b0;
      checks++;
      if (exp_q.size() !== 0) $display("[TB] FAIL bp_ignored_img: got queue size %0d expected 0", exp_q.size());
      else passed++;
      result_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({img_ready, result_valid, busy} !== 3'b100)
         $display("[TB] FAIL bp_release: got %b expected 100", {img_ready, result_valid, busy});
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] exp;
      int n;
      result_ready = 1'b1;
      img_valid = 1'b1;
      for (int img = 0; img < 2; img++) begin
         @(negedge clk);
         checks++;
         if (reset_acc !== 1'b1) $display("[TB] FAIL b2b_clear_%0d: got reset_acc=%b expected 1", img, reset_acc);
         else passed++;
         if (img == 1) img_valid = 1'b0;
         n = 1;
         while (result_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n !== 67) $display("[TB] FAIL b2b_latency_%0d: got %0d cycles expected 67", img, n);
         else passed++;
         exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
         checks++;
         if (result !== exp) $display("[TB] FAIL b2b_result_%0d: got %h expected %h", img, result, exp);
         else passed++;
         @(negedge clk);
         checks++;
         if ({img_ready, busy, result_valid} !== 3'b100)
            $display("[TB] FAIL b2b_idle_%0d: got %b expected 100", img, {img_ready, busy, result_valid});
         else passed++;
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() !== 0 || busy !== 1'b0)
         $display("[TB] FAIL b2b_drained: got queue=%0d busy=%b expected 0 0", exp_q.size(), busy);
      else passed++;
   endtask

   task automatic test_reset_mid_accum();
      logic [DATA_W-1:0] exp;
      logic seen;
      int n;
      result_ready = 1'b1;
      img_valid = 1'b1;
      @(negedge clk);
      img_valid = 1'b0;
      n = 0;
      while (cnt_val !== CNT_W'(30) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (cnt_val !== CNT_W'(30) || start !== 1'b0)
         $display("[TB] FAIL mid_reach_30: got cnt_val=%0d start=%b expected 30 0", cnt_val, start);
      else passed++;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({img_ready, busy, result_valid, start} !== 4'b1001 || cnt_val !== '0 || result !== '0)
         $display("[TB] FAIL mid_reset_idle: got %b cnt_val=%0d result=%h expected 1001 0 0000", {img_ready, busy, result_valid, start}, cnt_val, result);
      else passed++;
      seen = 1'b0;
      for (int i = 0; i < 80; i++) begin
         seen |= (result_valid !== 1'b0) | (busy !== 1'b0);
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b0) $display("[TB] FAIL mid_no_result: got activity=%b expected 0", seen);
      else passed++;
      img_valid = 1'b1;
      @(negedge clk);
      img_valid = 1'b0;
      n = 1;
      while (result_valid !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      exp = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      checks++;
      if (n !== 67 || result !== exp)
         $display("[TB] FAIL mid_recover: got %0d cycles result=%h expected 67 result=%h", n, result, exp);
      else passed++;
      @(negedge clk);
   endtask

   task automatic test_small_size();
      logic [DATA_W-1:0] exp;
      result_ready2 = 1'b1;
      img_valid2 = 1'b1;
      @(negedge clk);
      img_valid2 = 1'b0;
      checks++;
      if (reset_acc2 !== 1'b1) $display("[TB] FAIL small_clear: got reset_acc=%b expected 1", reset_acc2);
      else passed++;
      for (int i = 0; i < SMALL; i++) begin
         @(negedge clk);
         checks++;
         if (start2 !== 1'b0 || cnt_val2 !== CNT_W'(i))
            $display("[TB] FAIL small_accum_%0d: got start=%b cnt_val=%0d expected 0 %0d", i, start2, cnt_val2, i);
         else passed++;
      end
      @(negedge clk);
      checks++;
      if (start2 !== 1'b1 || cnt_val2 !== '0 || result_valid2 !== 1'b0)
         $display("[TB] FAIL small_settle: got start=%b cnt_val=%0d valid=%b expected 1 0 0", start2, cnt_val2, result_valid2);
      else passed++;
      @(negedge clk);
      exp = exp_q2.size() > 0 ? exp_q2.pop_front() : 'x;
      checks++;
      if (result_valid2 !== 1'b1 || result2 !== exp)
         $display("[TB] FAIL small_result: got valid=%b result=%h expected 1 %h", result_valid2, result2, exp);
      else passed++;
      @(negedge clk);
      checks++;
      if ({result_valid2, img_ready2, busy2} !== 3'b010)
         $display("[TB] FAIL small_idle: got %b expected 010", {result_valid2, img_ready2, busy2});
      else passed++;
   endtask

   // Hard stop in case a scenario wedges despite its own bounds
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no completion expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scenario sequence
   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_accum();
      test_small_size();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
